i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: maximum cycles allowed between m_start and m_done.
REQ-002 Clocking: one clock i_clk; reset reset_n is asynchronous and active-low.
REQ-003 i_clk  in  1  system clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req  in  2  per-requester transaction request, level, held until done.
REQ-006 req_rw  in  2  per-requester direction: 1 = read, 0 = write.
REQ-007 req_addr  in  14  per-requester 7-bit target address; requester k uses bits [7k+6:7k].
REQ-008 req_wdata  in  16  per-requester write byte; requester k uses bits [8k+7:8k].
REQ-009 gnt  out  2  one-hot grant, held from capture until done pulse.
REQ-010 done  out  2  one-cycle completion pulse to the granted requester.
REQ-011 nack  out  2  valid with done: 1 = address or data not acknowledged, or timeout.
REQ-012 rdata  out  8  read byte, valid with done when rw = 1.
REQ-013 m_start  out  1  one-cycle pulse launching one transaction on the master engine.
REQ-014 m_rw, m_addr, m_wdata  out  1/7/8  registered transaction fields, stable from m_start until m_done.
REQ-015 m_busy  in  1  master engine is mid-transaction.
REQ-016 m_done  in  1  one-cycle pulse at the end of the master's STOP.
REQ-017 m_addr_ack, m_data_ack  in  1/1  sampled SDA acknowledge bits: 0 = ACK, 1 = NACK.
REQ-018 m_rdata  in  8  byte read by the master.
REQ-019 timeout  out  1  one-cycle pulse when the timeout fires.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: when any req bit is set and m_busy = 0, select a winner, capture its rw/addr/wdata into m_* registers, set gnt, and go to ISSUE.
REQ-022 Arbitration SHALL be round-robin: priority goes to the requester not served last; after reset, requester 0 has priority.
REQ-023 If both requesters assert req in the same cycle, the non-last-served requester SHALL win, and the loser SHALL be served by the next transaction.
REQ-024 ISSUE: assert m_start for exactly one cycle, then go to WAIT.
REQ-025 WAIT: on m_done, latch nack = m_addr_ack | m_data_ack and rdata = m_rdata (read only; otherwise hold the previous value), then go to RESP.
REQ-026 RESP: pulse done[winner] for one cycle, clear gnt, update last-served, and return to IDLE.
REQ-027 Request-to-m_start latency SHALL be 2 cycles when IDLE and m_busy = 0.
REQ-028 A requester deasserting req after grant SHALL NOT abort the transaction; done still pulses.
REQ-029 A request arriving while m_busy = 1 in IDLE SHALL wait; no m_start is issued.
REQ-030 A new request SHALL NOT be captured in the same cycle as RESP; the earliest capture is the following IDLE cycle.
REQ-031 m_done seen outside WAIT SHALL be ignored.

Reset
REQ-032 On reset_n low, asynchronously: state = IDLE, gnt = 0, done = 0, nack = 0, rdata = 0x00, m_start = 0, m_rw = 0, m_addr = 0, m_wdata = 0, timeout = 0, last-served = 1, and the timeout counter = 0.
REQ-033 Reset during WAIT SHALL drop the transaction silently, with no done pulse.

Configuration
REQ-034 Macro I2C_ARB_TIMEOUT_EN:
- Defined: a counter SHALL run in WAIT. Reaching TIMEOUT_CYC - 1 without m_done pulses timeout, forces nack = 1 and rdata unchanged, and goes to RESP.
- Undefined: no counter is built, timeout is tied to 0, and WAIT exits only on m_done.

Structure
REQ-035 The shared package i2c_pkg SHALL hold the FSM state encoding, NUM_REQ = 2, and the ADDR_W = 7 and DATA_W = 8 constants.
REQ-036 The round-robin selector SHALL be a sub-module i2c_rr_sel (inputs: req, last; output: one-hot winner); it is combinational.

Verification
REQ-037 req = 01, rw = 0, addr 0x50, wdata 0xA5, master returns both acks = 0 -> m_start at cycle +2, m_addr = 0x50, m_wdata = 0xA5, done = 01 with nack = 0.
REQ-038 req = 10, rw = 1, addr 0x52, m_rdata = 0x45 -> done = 10, rdata = 0x45, nack = 0.
REQ-039 req = 11 simultaneously after reset -> requester 0 served first, then requester 1; gnt is never 11.
REQ-040 m_addr_ack = 1 at m_done -> done pulse with nack = 1.
REQ-041 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16, m_done withheld -> timeout pulses 16 cycles after m_start's WAIT entry, with nack = 1; without the macro, the FSM stays in WAIT.
REQ-042 reset_n pulsed low during WAIT -> all outputs return to reset values, no done pulse, and the next request is served normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared constants and types for the two-requester I2C master arbiter.
//   NUM_REQ / ADDR_W / DATA_W : requester count and transaction field widths
//   IDX_W                     : width of a requester index
//   ST_*                      : arbiter FSM state encoding
//   txn_t                     : one captured transaction (rw, addr, wdata)
//   onehot_to_idx()           : converts a one-hot requester vector to an index
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_rr_sel.sv
// -----------------------------------------------------------------------------
// i2c_rr_sel
// Combinational round-robin selector. The search starts at the requester
// after the last-served one, so the requester that was not served last wins
// a tie.
//   req    in  NUM_REQ  active requests
//   last   in  IDX_W    index of the last-served requester
//   winner out NUM_REQ  one-hot winner (all zero when no request is active)
// -----------------------------------------------------------------------------
module i2c_rr_sel
    import i2c_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner
);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Scan requesters in rotating order starting just after the last-served one.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_arbiter
// Round-robin arbiter sharing one I2C master engine between two requesters.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Parameter
//   TIMEOUT_CYC   maximum WAIT cycles before the transaction is abandoned
//                 (only meaningful when I2C_ARB_TIMEOUT_EN is defined)
// Configuration macro
//   I2C_ARB_TIMEOUT_EN  defined: WAIT watchdog counter built, timeout pulses
//                       undefined: no counter, timeout tied low
// Ports
//   i_clk, reset_n                 clock, asynchronous active-low reset
//   req, req_rw, req_addr, req_wdata   per-requester transaction requests
//   gnt, done, nack, rdata         per-requester grant / completion / status
//   m_start, m_rw, m_addr, m_wdata registered transaction to the master engine
//   m_busy, m_done, m_addr_ack, m_data_ack, m_rdata   master engine status
//   timeout                        one-cycle watchdog pulse
// -----------------------------------------------------------------------------
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       i_clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         nack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       m_start,
    output logic                       m_rw,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wdata,
    input  logic                       m_busy,
    input  logic                       m_done,
    input  logic                       m_addr_ack,
    input  logic                       m_data_ack,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic                       timeout
);

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   last_r;
    logic [NUM_REQ-1:0] win_oh_s;
    logic [IDX_W-1:0]   win_idx_s;
    txn_t               sel_txn_s;
    logic               tmo_hit_s;

    i2c_rr_sel u_rr_sel (
        .req    (req),
        .last   (last_r),
        .winner (win_oh_s)
    );

    // Pick the winning requester's transaction fields out of the packed buses.
    always_comb begin
        win_idx_s       = onehot_to_idx(win_oh_s);
        sel_txn_s.rw    = req_rw[win_idx_s];
        sel_txn_s.addr  = req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
        sel_txn_s.wdata = req_wdata[int'(win_idx_s)*DATA_W +: DATA_W];
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt_r;

    // Watchdog fires on the WAIT cycle where the count reaches its last value;
    // a simultaneous m_done takes precedence.
    always_comb begin
        if ((state_r == ST_WAIT) && !m_done && (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1))) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // WAIT-cycle counter and the registered timeout pulse.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= tmo_hit_s;
            if ((state_r == ST_WAIT) && !m_done && !tmo_hit_s) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end
`else
    // No watchdog: WAIT only ends on m_done.
    always_comb begin
        tmo_hit_s = 1'b0;
    end

    assign timeout = 1'b0;
`endif

    // Arbiter FSM with registered grant, completion and master-side outputs.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            last_r  <= IDX_W'(1);
            gnt     <= '0;
            done    <= '0;
            nack    <= '0;
            rdata   <= 8'h00;
            m_start <= 1'b0;
            m_rw    <= 1'b0;
            m_addr  <= 7'h00;
            m_wdata <= 8'h00;
        end else begin
            m_start <= 1'b0;
            done    <= '0;
            case (state_r)
                ST_IDLE: begin
                    if ((|req) && !m_busy) begin
                        gnt     <= win_oh_s;
                        m_rw    <= sel_txn_s.rw;
                        m_addr  <= sel_txn_s.addr;
                        m_wdata <= sel_txn_s.wdata;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_start <= 1'b1;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        nack <= {NUM_REQ{m_addr_ack | m_data_ack}};
                        if (m_rw) begin
                            rdata <= m_rdata;
                        end
                        state_r <= ST_RESP;
                    end else if (tmo_hit_s) begin
                        nack    <= {NUM_REQ{1'b1}};
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // done follows the grant; requester inputs are not sampled here.
                    done    <= gnt;
                    gnt     <= '0;
                    last_r  <= onehot_to_idx(gnt);
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

    localparam int TCYC = 16;

    logic        i_clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, req_rw;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt, done, nack;
    logic [7:0]  rdata;
    logic        m_start, m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic        m_busy, m_done, m_addr_ack, m_data_ack;
    logic [7:0]  m_rdata;
    logic        timeout;

    i2c_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
        .i_clk(i_clk), .reset_n(reset_n), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .nack(nack), .rdata(rdata), .m_start(m_start), .m_rw(m_rw),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
        .m_addr_ack(m_addr_ack), .m_data_ack(m_data_ack), .m_rdata(m_rdata),
        .timeout(timeout)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int gnt_both_cnt = 0;

    always @(negedge i_clk) begin
        if (gnt === 2'b11) gnt_both_cnt++;
    end

    // observations filled by master_serve
    logic       obs_start_ok, obs_done_ok;
    int         obs_lat;
    logic       obs_rw;
    logic [6:0] obs_addr;
    logic [7:0] obs_wdata, obs_rdata;
    logic [1:0] obs_gnt, obs_done, obs_nack, obs_gnt_at_done;

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[k]          = rw;
        req_addr[7*k +: 7] = a;
        req_wdata[8*k +: 8] = d;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req = 2'b00; req_rw = 2'b00; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_addr_ack = 1'b0; m_data_ack = 1'b0; m_rdata = 8'h00;
        step; step;
        reset_n = 1'b1;
        step;
    endtask

    // Behaves as the master engine: waits for m_start, answers after dly cycles,
    // then waits for the done pulse. Records what it saw; checks live in callers.
    task automatic master_serve(input int dly, input logic aack, input logic dack, input logic [7:0] rd);
        obs_start_ok = 1'b0; obs_done_ok = 1'b0; obs_lat = 0;
        obs_done = 2'b00; obs_nack = 2'b00; obs_rdata = 8'h00; obs_gnt_at_done = 2'b00;
        for (int i = 1; i <= 20 && !obs_start_ok; i++) begin
            step;
            if (m_start === 1'b1) begin
                obs_start_ok = 1'b1; obs_lat = i;
                obs_rw = m_rw; obs_addr = m_addr; obs_wdata = m_wdata; obs_gnt = gnt;
            end
        end
        if (!obs_start_ok) return;
        repeat (dly) step;
        m_done = 1'b1; m_addr_ack = aack; m_data_ack = dack; m_rdata = rd;
        step;
        m_done = 1'b0; m_addr_ack = 1'b0; m_data_ack = 1'b0;
        for (int i = 0; i < 5 && !obs_done_ok; i++) begin
            step;
            if (done !== 2'b00) begin
                obs_done_ok = 1'b1; obs_done = done; obs_nack = nack;
                obs_rdata = rdata; obs_gnt_at_done = gnt;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        checks++;
        if ({gnt, done, nack, rdata, m_start, m_rw, m_addr, m_wdata, timeout} !== 39'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {gnt, done, nack, rdata, m_start, m_rw, m_addr, m_wdata, timeout});
        end
        do_reset;
        checks++;
        if (gnt !== 2'b00 || m_start !== 1'b0) begin
            errors++; $display("FAIL reset_idle: gnt=%b m_start=%b expected 00/0", gnt, m_start);
        end
    endtask

    task automatic test_write;
        set_req(0, 1'b0, 7'h50, 8'hA5);
        req = 2'b01;
        master_serve(2, 1'b0, 1'b0, 8'h00);
        checks++;
        if (!obs_start_ok || obs_lat != 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", obs_lat); end
        checks++;
        if (obs_addr !== 7'h50 || obs_wdata !== 8'hA5 || obs_rw !== 1'b0) begin
            errors++; $display("FAIL wr_fields: got %h/%h/%b expected 50/a5/0", obs_addr, obs_wdata, obs_rw);
        end
        checks++;
        if (obs_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", obs_gnt); end
        checks++;
        if (!obs_done_ok || obs_done !== 2'b01 || obs_nack !== 2'b00) begin
            errors++; $display("FAIL wr_done: got done=%b nack=%b expected 01/00", obs_done, obs_nack);
        end
        checks++;
        if (obs_gnt_at_done !== 2'b00) begin errors++; $display("FAIL wr_gnt_clear: got %b expected 00", obs_gnt_at_done); end
        req = 2'b00;
        step;
        checks++;
        if (done !== 2'b00) begin errors++; $display("FAIL wr_done_pulse: got %b expected 00", done); end
    endtask

    task automatic test_read;
        set_req(1, 1'b1, 7'h52, 8'h00);
        req = 2'b10;
        master_serve(3, 1'b0, 1'b0, 8'h45);
        checks++;
        if (!obs_start_ok || obs_addr !== 7'h52 || obs_rw !== 1'b1) begin
            errors++; $display("FAIL rd_fields: got %h/%b expected 52/1", obs_addr, obs_rw);
        end
        checks++;
        if (!obs_done_ok || obs_done !== 2'b10 || obs_rdata !== 8'h45 || obs_nack !== 2'b00) begin
            errors++; $display("FAIL rd_done: got %b/%h/%b expected 10/45/00", obs_done, obs_rdata, obs_nack);
        end
        req = 2'b00;
        step;
    endtask

    task automatic test_nack;
        set_req(0, 1'b0, 7'h11, 8'h22);
        req = 2'b01;
        master_serve(1, 1'b1, 1'b0, 8'h99);
        checks++;
        if (!obs_done_ok || obs_done !== 2'b01 || obs_nack === 2'b00) begin
            errors++; $display("FAIL addr_nack: got done=%b nack=%b expected 01 with nack set", obs_done, obs_nack);
        end
        checks++;
        if (obs_rdata !== 8'h45) begin errors++; $display("FAIL wr_rdata_hold: got %h expected 45", obs_rdata); end
        req = 2'b00; step;
        req = 2'b01;
        master_serve(0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (!obs_done_ok || obs_nack === 2'b00) begin
            errors++; $display("FAIL data_nack: got nack=%b expected set", obs_nack);
        end
        req = 2'b00; step;
    endtask

    task automatic test_back_to_back;
        int base;
        do_reset;
        base = gnt_both_cnt;
        set_req(0, 1'b0, 7'h21, 8'h01);
        set_req(1, 1'b0, 7'h42, 8'h02);
        req = 2'b11;
        master_serve(1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_done !== 2'b01 || obs_addr !== 7'h21) begin
            errors++; $display("FAIL b2b_first: got done=%b addr=%h expected 01/21", obs_done, obs_addr);
        end
        req = 2'b10;
        master_serve(1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_done !== 2'b10 || obs_addr !== 7'h42) begin
            errors++; $display("FAIL b2b_second: got done=%b addr=%h expected 10/42", obs_done, obs_addr);
        end
        req = 2'b00; step;
        checks++;
        if (gnt_both_cnt != base) begin errors++; $display("FAIL b2b_gnt_onehot: got %0d cycles of gnt=11 expected 0", gnt_both_cnt - base); end
    endtask

    task automatic test_busy;
        logic bad;
        bad = 1'b0;
        m_busy = 1'b1;
        set_req(0, 1'b0, 7'h33, 8'h44);
        req = 2'b01;
        repeat (6) begin
            step;
            if (m_start !== 1'b0 || gnt !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL busy_hold: got activity expected none while busy"); end
        m_busy = 1'b0;
        master_serve(0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (!obs_start_ok || obs_lat != 2) begin errors++; $display("FAIL busy_release_lat: got %0d expected 2", obs_lat); end
        req = 2'b00; step;
    endtask

    task automatic test_abort_and_stray;
        logic bad;
        set_req(1, 1'b0, 7'h0A, 8'h0B);
        req = 2'b10;
        step;
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL abort_gnt: got %b expected 10", gnt); end
        req = 2'b00;
        master_serve(0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (!obs_done_ok || obs_done !== 2'b10) begin errors++; $display("FAIL abort_done: got %b expected 10", obs_done); end
        step;
        bad = 1'b0;
        m_done = 1'b1; m_addr_ack = 1'b1;
        step;
        m_done = 1'b0; m_addr_ack = 1'b0;
        repeat (4) begin
            step;
            if (done !== 2'b00 || gnt !== 2'b00 || nack !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL stray_done: got response expected none"); end
    endtask

    task automatic test_timeout;
        logic seen, bad;
        int   n;
        set_req(0, 1'b1, 7'h77, 8'h00);
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step;
            if (m_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL tmo_start: got no m_start expected one"); end
`ifdef I2C_ARB_TIMEOUT_EN
        seen = 1'b0; n = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step;
            if (timeout === 1'b1) begin seen = 1'b1; n = i; end
        end
        checks++;
        if (!seen || n != TCYC || nack === 2'b00) begin
            errors++; $display("FAIL tmo_pulse: got cycle %0d nack=%b expected %0d with nack", n, nack, TCYC);
        end
        step;
        checks++;
        if (done !== 2'b01 || timeout !== 1'b0 || rdata !== 8'h00) begin
            errors++; $display("FAIL tmo_done: got done=%b tmo=%b rdata=%h expected 01/0/00", done, timeout, rdata);
        end
        req = 2'b00; step;
`else
        bad = 1'b0; n = 0;
        repeat (40) begin
            step;
            if (done !== 2'b00 || timeout !== 1'b0 || gnt !== 2'b01) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL no_tmo_wait: got exit from WAIT expected stay (n=%0d)", n); end
        req = 2'b00;
        master_serve(0, 1'b0, 1'b0, 8'h00);
        m_done = 1'b1; step; m_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step;
            if (done === 2'b01) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL no_tmo_done: got none expected done=01"); end
`endif
    endtask

    task automatic test_reset_wait;
        logic seen, bad;
        set_req(1, 1'b1, 7'h19, 8'h00);
        req = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step;
            if (m_start === 1'b1) seen = 1'b1;
        end
        step; step;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (!seen || {gnt, done, nack, rdata, m_start, m_rw, m_addr, m_wdata, timeout} !== 39'h0) begin
            errors++; $display("FAIL rst_wait_outputs: got %h expected 0", {gnt, done, nack, rdata, m_start, m_rw, m_addr, m_wdata, timeout});
        end
        req = 2'b00;
        step;
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            step;
            if (done !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rst_wait_nodone: got done pulse expected none"); end
        set_req(0, 1'b0, 7'h05, 8'h06);
        req = 2'b11;
        master_serve(0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (!obs_done_ok || obs_done !== 2'b01 || obs_addr !== 7'h05) begin
            errors++; $display("FAIL rst_wait_next: got done=%b addr=%h expected 01/05", obs_done, obs_addr);
        end
        req = 2'b00; step;
    endtask

    // Transaction-level model: pending set, last-served index, last read byte.
    task automatic test_random;
        logic [1:0] pend;
        logic       mrw[2];
        logic [6:0] madr[2];
        logic [7:0] mwd[2];
        int         last_m, w;
        logic [7:0] rdata_m, rd;
        logic       aa, da;
        do_reset;
        pend = 2'b00; last_m = 1; rdata_m = 8'h00;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
                    mrw[k] = 1'($urandom_range(0, 1)); madr[k] = 7'($urandom); mwd[k] = 8'($urandom);
                    set_req(k, mrw[k], madr[k], mwd[k]);
                    pend[k] = 1'b1;
                end
            end
            if (pend == 2'b00) begin
                k_pick: begin
                    int k;
                    k = $urandom_range(0, 1);
                    mrw[k] = 1'($urandom_range(0, 1)); madr[k] = 7'($urandom); mwd[k] = 8'($urandom);
                    set_req(k, mrw[k], madr[k], mwd[k]);
                    pend[k] = 1'b1;
                end
            end
            req = pend;
            w = (pend == 2'b11) ? (1 - last_m) : (pend[0] ? 0 : 1);
            aa = ($urandom_range(0, 3) == 0); da = ($urandom_range(0, 3) == 0);
            rd = 8'($urandom);
            master_serve($urandom_range(0, 5), aa, da, rd);
            if (mrw[w]) rdata_m = rd;
            checks++;
            if (!obs_start_ok || obs_addr !== madr[w] || obs_wdata !== mwd[w] || obs_rw !== mrw[w]) begin
                errors++; $display("FAIL rand_fields[%0d]: got %h/%h/%b expected %h/%h/%b", r, obs_addr, obs_wdata, obs_rw, madr[w], mwd[w], mrw[w]);
            end
            checks++;
            if (!obs_done_ok || obs_done !== 2'(1 << w) || (obs_nack !== 2'b00) !== (aa | da) || obs_rdata !== rdata_m) begin
                errors++; $display("FAIL rand_done[%0d]: got %b/%b/%h expected winner %0d nack %b rdata %h", r, obs_done, obs_nack, obs_rdata, w, aa | da, rdata_m);
            end
            pend[w] = 1'b0;
            req = pend;
            last_m = w;
        end
        req = 2'b00;
        repeat (3) step;
    endtask

    initial begin
        reset_n = 1'b0;
        req = 2'b00; req_rw = 2'b00; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_addr_ack = 1'b0; m_data_ack = 1'b0; m_rdata = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_nack;
        test_back_to_back;
        test_busy;
        test_abort_and_stray;
        test_timeout;
        test_reset_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
